// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: funct3 access codes, MEM-stage state encoding, bus widths.
package pipe_pkg;
    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    // Legal = known size code and the address naturally aligned for that size.
    function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~a[0];
            F3_LW:         ok = (a == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
    import pipe_pkg::*;

    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [BE_W-1:0] mem_be_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half from a read word and sign- or zero-extends it to 32 bits.
module load_align
    import pipe_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory controller: issues one req/ack access per load/store, stalling until done.
// Latency IDLE + BUSY(>=1) + DONE; aborts with bus_err_o after TIMEOUT BUSY cycles without ack.
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   ALUres_i,
    input  logic [XLEN-1:0]   RS2data_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [2:0]        funct3_i,
    output logic [XLEN-1:0]   Memdata_o,
    output logic              stall_o,
    output logic              addr_err_o,
    output logic              bus_err_o,
    mem_access_stage_if.master mem
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]      alo_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] memdata_q;
    logic            bus_err_q;
    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [BE_W-1:0] be_q;

    logic            access;
    logic            is_store;
    logic            legal;
    logic [BE_W-1:0] be_d;
    logic [XLEN-1:0] wdata_d;
    logic [XLEN-1:0] load_data;

    // Read wins when both strobes are set.
    assign access   = MemRead_i | MemWrite_i;
    assign is_store = MemWrite_i & ~MemRead_i;
    assign legal    = access_legal(funct3_i, ALUres_i[1:0]);

    always_comb begin
        be_d    = '1;
        wdata_d = '0;
        if (is_store) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << ALUres_i[1:0];
                    wdata_d = {4{RS2data_i[7:0]}};
                end
                2'b01: begin
                    be_d    = ALUres_i[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{RS2data_i[15:0]}};
                end
                default: wdata_d = RS2data_i;
            endcase
        end
    end

    load_align u_load_align (
        .rdata_i   (mem.mem_rdata_i),
        .addr_lo_i (alo_q),
        .funct3_i  (f3_q),
        .data_o    (load_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= MEM_IDLE;
            cnt_q     <= '0;
            alo_q     <= '0;
            f3_q      <= '0;
            memdata_q <= '0;
            bus_err_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            case (state_q)
                MEM_IDLE: begin
                    if (access && !legal) begin
                        memdata_q <= '0;
                    end else if (access) begin
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {ALUres_i[XLEN-1:2], 2'b00};
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        alo_q   <= ALUres_i[1:0];
                        f3_q    <= funct3_i;
                        cnt_q   <= '0;
                        state_q <= MEM_BUSY;
                    end
                end
                MEM_BUSY: begin
                    // An ack arriving on the timeout edge still completes normally.
                    if (mem.mem_ack_i) begin
                        req_q     <= 1'b0;
                        memdata_q <= we_q ? '0 : load_data;
                        state_q   <= MEM_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                        memdata_q <= '0;
                        state_q   <= MEM_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                MEM_DONE: begin
                    bus_err_q <= 1'b0;
                    state_q   <= MEM_IDLE;
                end
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

    assign stall_o    = (state_q == MEM_BUSY) || ((state_q == MEM_IDLE) && access && legal);
    assign addr_err_o = (state_q == MEM_IDLE) && access && !legal;
    assign Memdata_o  = memdata_q;
    assign bus_err_o  = bus_err_q;

    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign mem.mem_be_o    = be_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: memory responder with programmable ack delay, result scoreboard.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUres;
    logic [31:0] RS2data;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Memdata;
    logic        stall_o;
    logic        addr_err;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb_q[$];

    mem_access_stage_if mif ();

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ALUres_i   (ALUres),
        .RS2data_i  (RS2data),
        .MemRead_i  (MemRead),
        .MemWrite_i (MemWrite),
        .funct3_i   (funct3),
        .Memdata_o  (Memdata),
        .stall_o    (stall_o),
        .addr_err_o (addr_err),
        .bus_err_o  (bus_err),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one access and plays memory: ack on the ack_dly-th cycle of mem_req_o (0 = never).
    task automatic run_access(input string tag, input logic [31:0] addr, input logic [31:0] wdat,
                              input logic rd, input logic wr, input logic [2:0] f3,
                              input int ack_dly, input logic [31:0] rdat,
                              input logic [31:0] exp_data, input logic exp_berr,
                              input int exp_stall, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata);
        int n_stall;
        int n_req;
        bit done;
        logic [32:0] exp_item;
        @(negedge clk);
        ALUres = addr; RS2data = wdat; MemRead = rd; MemWrite = wr; funct3 = f3;
        mif.mem_rdata_i = rdat;
        sb_q.push_back({exp_berr, exp_data});
        #1;
        chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
        n_stall = 0; n_req = 0; done = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (mif.mem_req_o) begin
                n_req++;
                if (n_req == 1) begin
                    chk({tag, "_mem_addr"}, mif.mem_addr_o, addr & 32'hFFFF_FFFC);
                    chk({tag, "_mem_be"}, 32'(mif.mem_be_o), 32'(exp_be));
                    chk({tag, "_mem_we"}, 32'(mif.mem_we_o), 32'(wr & ~rd));
                    if (wr && !rd) chk({tag, "_mem_wdata"}, mif.mem_wdata_o, exp_wdata);
                end
            end
            if (stall_o) begin
                n_stall++;
            end else if (n_req > 0) begin
                done = 1'b1;
                chk({tag, "_req_in_done"}, 32'(mif.mem_req_o), 32'd0);
                if (sb_q.size() == 0) begin
                    chk({tag, "_sb_empty"}, 32'd1, 32'd0);
                end else begin
                    exp_item = sb_q.pop_front();
                    chk({tag, "_Memdata"}, Memdata, exp_item[31:0]);
                    chk({tag, "_bus_err"}, 32'(bus_err), 32'(exp_item[32]));
                end
                MemRead = 1'b0; MemWrite = 1'b0;
            end
            mif.mem_ack_i = mif.mem_req_o && (n_req == ack_dly);
            if (!done) @(negedge clk);
        end
        mif.mem_ack_i = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0;
        chk({tag, "_completed"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, n_stall, exp_stall);
        chk({tag, "_req_cycles"}, n_req, exp_stall - 1);
        @(negedge clk);
        chk({tag, "_bus_err_cleared"}, 32'(bus_err), 32'd0);
        chk({tag, "_idle_stall"}, 32'(stall_o), 32'd0);
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] addr, input logic [2:0] f3);
        @(negedge clk);
        ALUres = addr; MemRead = 1'b1; MemWrite = 1'b0; funct3 = f3;
        #1;
        chk({tag, "_addr_err"}, 32'(addr_err), 32'd1);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        @(negedge clk);
        chk({tag, "_no_req"}, 32'(mif.mem_req_o), 32'd0);
        chk({tag, "_Memdata_zero"}, Memdata, 32'd0);
        MemRead = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ALUres = '0; RS2data = '0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = '0;
        mif.mem_ack_i = 1'b0; mif.mem_rdata_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_Memdata", Memdata, 32'd0);
        chk("rst_req", 32'(mif.mem_req_o), 32'd0);
        chk("rst_we", 32'(mif.mem_we_o), 32'd0);
        chk("rst_addr", mif.mem_addr_o, 32'd0);
        chk("rst_wdata", mif.mem_wdata_o, 32'd0);
        chk("rst_be", 32'(mif.mem_be_o), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);

        run_access("lw100", 32'h100, 32'h0, 1, 0, 3'b010, 2, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 4'hF, 32'h0);
        run_access("lb203", 32'h203, 32'h0, 1, 0, 3'b000, 1, 32'h80112233, 32'hFFFFFF80, 0, 2, 4'hF, 32'h0);
        run_access("lbu203", 32'h203, 32'h0, 1, 0, 3'b100, 3, 32'h80112233, 32'h00000080, 0, 4, 4'hF, 32'h0);
        run_access("lh202", 32'h202, 32'h0, 1, 0, 3'b001, 1, 32'h80112233, 32'hFFFF8011, 0, 2, 4'hF, 32'h0);
        run_access("lhu200", 32'h200, 32'h0, 1, 0, 3'b101, 1, 32'h80112233, 32'h00002233, 0, 2, 4'hF, 32'h0);
        run_access("sh42", 32'h42, 32'h1234ABCD, 0, 1, 3'b001, 2, 32'h55555555, 32'h0, 0, 3, 4'b1100, 32'hABCDABCD);
        run_access("sb41", 32'h41, 32'h000000A5, 0, 1, 3'b000, 1, 32'h77777777, 32'h0, 0, 2, 4'b0010, 32'hA5A5A5A5);
        run_access("sw44", 32'h44, 32'hCAFEF00D, 0, 1, 3'b010, 1, 32'h0, 32'h0, 0, 2, 4'hF, 32'hCAFEF00D);
        run_access("rdwr108", 32'h108, 32'h99999999, 1, 1, 3'b010, 1, 32'h01234567, 32'h01234567, 0, 2, 4'hF, 32'h0);

        run_illegal("lw102", 32'h102, 3'b010);
        run_access("lw104", 32'h104, 32'h0, 1, 0, 3'b010, 1, 32'h11111111, 32'h11111111, 0, 2, 4'hF, 32'h0);
        run_illegal("f3_011", 32'h100, 3'b011);
        run_illegal("lh201", 32'h201, 3'b001);

        run_access("lw_prev", 32'h10C, 32'h0, 1, 0, 3'b010, 1, 32'h22222222, 32'h22222222, 0, 2, 4'hF, 32'h0);
        run_access("timeout", 32'h100, 32'h0, 1, 0, 3'b010, 0, 32'hFFFFFFFF, 32'h0, 1, 17, 4'hF, 32'h0);
        run_access("ack16", 32'h100, 32'h0, 1, 0, 3'b010, 16, 32'h5A5A1234, 32'h5A5A1234, 0, 17, 4'hF, 32'h0);

        // Reset during the second BUSY cycle abandons the request.
        @(negedge clk);
        ALUres = 32'h300; MemRead = 1'b1; funct3 = 3'b010; mif.mem_rdata_i = 32'hABABABAB;
        @(negedge clk);
        chk("rstbusy_req_first", 32'(mif.mem_req_o), 32'd1);
        @(negedge clk);
        rst = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstbusy_req", 32'(mif.mem_req_o), 32'd0);
        chk("rstbusy_stall", 32'(stall_o), 32'd0);
        chk("rstbusy_Memdata", Memdata, 32'd0);
        chk("rstbusy_be", 32'(mif.mem_be_o), 32'd0);
        mif.mem_ack_i = 1'b1;
        @(negedge clk);
        mif.mem_ack_i = 1'b0;
        chk("late_ack_stall", 32'(stall_o), 32'd0);
        chk("late_ack_req", 32'(mif.mem_req_o), 32'd0);
        chk("late_ack_Memdata", Memdata, 32'd0);
        run_access("lw_after_rst", 32'h300, 32'h0, 1, 0, 3'b010, 2, 32'h0BADF00D, 32'h0BADF00D, 0, 3, 4'hF, 32'h0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
